// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: field widths, channel opcodes and the
// responder state encoding.
package tl_pkg;

  localparam int OPCODE_WIDTH = 3;
  localparam int PARAM_WIDTH  = 3;
  localparam int SIZE_WIDTH   = 3;
  localparam int SINK_WIDTH   = 1;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    A_PUT_FULL_DATA    = 3'd0,
    A_PUT_PARTIAL_DATA = 3'd1,
    A_GET              = 3'd4
  } a_opcode_e;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } d_opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } tl_state_e;

endpackage

// File: rtl/tl_mem_array.sv
// Word-organised storage with per-byte write enables and a registered read
// port. Contents are intentionally not reset.
module tl_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  localparam int MASK_WIDTH = DATA_WIDTH / 8,
  localparam int IDX_WIDTH  = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [IDX_WIDTH-1:0]  index,
  input  logic [MASK_WIDTH-1:0] wr_mask,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (wr_mask[i]) begin
          mem[index][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_data <= mem[index];
    end
  end

endmodule

// File: rtl/tl_mem_responder.sv
// TileLink-UL memory slave: accepts one A-channel request at a time, waits
// LATENCY cycles, then holds the D-channel response until it is taken.
module tl_mem_responder
  import tl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    SRC_WIDTH  = 2,
  parameter int                    MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    LATENCY    = 1,
  localparam int                   MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0]  a_param,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic [SRC_WIDTH-1:0]    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0]  d_param,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic [SRC_WIDTH-1:0]    d_source,
  output logic [SINK_WIDTH-1:0]   d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error,
  output logic                    mem_busy
);

  localparam int          LANE_LOG2 = $clog2(MASK_WIDTH);
  localparam int          IDX_WIDTH = $clog2(MEM_DEPTH);
  localparam logic [63:0] BASE_EXT  = 64'(BASE_ADDR);
  localparam logic [63:0] LIMIT_EXT = BASE_EXT + 64'(MEM_DEPTH) * 64'(MASK_WIDTH);
  localparam logic [3:0]  LAT_LOAD  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  tl_state_e               state, state_next;
  logic [3:0]              wait_cnt, wait_cnt_next;
  logic                    accept, enter_resp, sel_live;
  logic                    bad_opcode, out_of_range, bad_size, misaligned, req_error;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [IDX_WIDTH-1:0]    req_index;

  logic [OPCODE_WIDTH-1:0] cap_opcode;
  logic [SIZE_WIDTH-1:0]   cap_size;
  logic [SRC_WIDTH-1:0]    cap_source;
  logic [IDX_WIDTH-1:0]    cap_index;
  logic [MASK_WIDTH-1:0]   cap_mask;
  logic [DATA_WIDTH-1:0]   cap_data;
  logic                    cap_error;

  logic [OPCODE_WIDTH-1:0] acc_opcode;
  logic                    acc_error;
  logic [IDX_WIDTH-1:0]    acc_index;
  logic [MASK_WIDTH-1:0]   acc_mask;
  logic [DATA_WIDTH-1:0]   acc_data;
  logic                    mem_wr_en, mem_rd_en;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    unused_bits;

  assign a_ready = reset_n && (state == ST_IDLE);
  assign accept  = a_valid && a_ready;

  // Range compare is done in 64 bits so a region ending at the top of the
  // address space cannot wrap into a false "in range" result.
  always_comb begin
    bad_opcode   = !((a_opcode == A_PUT_FULL_DATA) || (a_opcode == A_PUT_PARTIAL_DATA) ||
                     (a_opcode == A_GET));
    out_of_range = (64'(a_address) < BASE_EXT) || (64'(a_address) >= LIMIT_EXT);
    bad_size     = int'(a_size) > LANE_LOG2;
    misaligned   = 1'b0;
    for (int i = 0; i < LANE_LOG2; i++) begin
      if ((i < int'(a_size)) && a_address[i]) begin
        misaligned = 1'b1;
      end
    end
    req_error = bad_opcode || out_of_range || bad_size || misaligned;
  end

  assign offset      = a_address - BASE_ADDR;
  assign req_index   = offset[LANE_LOG2 +: IDX_WIDTH];
  assign unused_bits = ^{a_param, offset};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      cap_opcode <= '0;
      cap_size   <= '0;
      cap_source <= '0;
      cap_index  <= '0;
      cap_mask   <= '0;
      cap_data   <= '0;
      cap_error  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (accept) begin
        cap_opcode <= a_opcode;
        cap_size   <= a_size;
        cap_source <= a_source;
        cap_index  <= req_index;
        cap_mask   <= a_mask;
        cap_data   <= a_data;
        cap_error  <= req_error;
      end
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next    = (LATENCY == 0) ? ST_RESP : ST_WAIT;
          wait_cnt_next = LAT_LOAD;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = ST_RESP;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (d_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // With zero latency the access edge is the accept edge, so the memory
  // must see the live A fields rather than the not-yet-loaded capture.
  assign enter_resp = (state_next == ST_RESP) && (state != ST_RESP);
  assign sel_live   = (state == ST_IDLE);
  assign acc_opcode = sel_live ? a_opcode  : cap_opcode;
  assign acc_error  = sel_live ? req_error : cap_error;
  assign acc_index  = sel_live ? req_index : cap_index;
  assign acc_mask   = sel_live ? a_mask    : cap_mask;
  assign acc_data   = sel_live ? a_data    : cap_data;
  assign mem_wr_en  = enter_resp && !acc_error && (acc_opcode != A_GET);
  assign mem_rd_en  = enter_resp && !acc_error && (acc_opcode == A_GET);

  tl_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem_array (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .rd_en   (mem_rd_en),
    .index   (acc_index),
    .wr_mask (acc_mask),
    .wr_data (acc_data),
    .rd_data (rd_data)
  );

  assign d_valid  = (state == ST_RESP);
  assign d_opcode = (cap_opcode == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
  assign d_param  = '0;
  assign d_sink   = '0;
  assign d_size   = cap_size;
  assign d_source = cap_source;
  assign d_error  = d_valid && cap_error;
  assign d_data   = (d_valid && !cap_error && (cap_opcode == A_GET)) ? rd_data : '0;
  assign mem_busy = (state != ST_IDLE);

endmodule

// File: doc/tl_mem_responder.md
TL_MEM_RESPONDER -- requirements
Module: tl_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; MASK_WIDTH is DATA_WIDTH/8 bytes.
REQ-003 SHALL have parameter SRC_WIDTH, default 2, source ID width.
REQ-004 SHALL have parameter MEM_DEPTH, default 256, words of storage.
REQ-005 SHALL have parameter BASE_ADDR, default 0, byte address of word 0.
REQ-006 SHALL have parameter LATENCY, default 1, extra wait cycles (0..15) between accept and response.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic uses its rising edge.
REQ-008 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-009 SHALL have port a_valid, input, 1, Channel A request valid.
REQ-010 SHALL have port a_ready, output, 1, Channel A accept.
REQ-011 SHALL have port a_opcode, input, OPCODE_WIDTH, where 0=PutFullData, 1=PutPartialData, 4=Get.
REQ-012 SHALL have port a_param, input, PARAM_WIDTH, ignored.
REQ-013 SHALL have port a_size, input, SIZE_WIDTH, log2 of bytes.
REQ-014 SHALL have port a_source, input, SRC_WIDTH, requester ID.
REQ-015 SHALL have port a_address, input, ADDR_WIDTH, byte address.
REQ-016 SHALL have port a_mask, input, MASK_WIDTH, byte lanes.
REQ-017 SHALL have port a_data, input, DATA_WIDTH, write data.
REQ-018 SHALL have port d_valid, output, 1, Channel D response valid.
REQ-019 SHALL have port d_ready, input, 1, Channel D accept.
REQ-020 SHALL have port d_opcode, output, OPCODE_WIDTH, where 0=AccessAck, 1=AccessAckData.
REQ-021 SHALL have port d_param, output, PARAM_WIDTH, always 0.
REQ-022 SHALL have port d_size, output, SIZE_WIDTH, echo of the captured a_size.
REQ-023 SHALL have port d_source, output, SRC_WIDTH, echo of the captured a_source.
REQ-024 SHALL have port d_sink, output, SINK_WIDTH, always 0.
REQ-025 SHALL have port d_data, output, DATA_WIDTH, read data; 0 for AccessAck and for errors.
REQ-026 SHALL have port d_error, output, 1, request was denied.
REQ-027 SHALL have port mem_busy, output, 1, high when the FSM is not in IDLE.

Function
REQ-028 SHALL implement the FSM IDLE -> WAIT -> RESP -> IDLE; the FSM goes IDLE -> RESP directly when LATENCY=0.
REQ-029 SHALL drive a_ready=1 only in IDLE; on a_valid&&a_ready it captures all A fields, loads the wait counter with LATENCY-1, and exits IDLE.
REQ-030 SHALL, in WAIT, decrement the counter each cycle and move to RESP in the cycle after the counter reaches 0, giving an accept-to-d_valid latency of 1+LATENCY cycles.
REQ-031 SHALL perform the memory access on the clock edge that enters RESP: Put writes only the lanes whose mask bit is set; Get registers the whole word.
REQ-032 SHALL index the memory as word = (address-BASE_ADDR) >> log2(MASK_WIDTH).
REQ-033 SHALL hold d_valid=1 and all D fields stable in RESP until d_ready, then return to IDLE; a new accept is possible no earlier than the next cycle, so there is one outstanding request.
REQ-034 SHALL flag an error for any of: opcode not in {0,1,4}; address < BASE_ADDR or >= BASE_ADDR+MEM_DEPTH*MASK_WIDTH; a_size > log2(MASK_WIDTH); address not aligned to 2^a_size.
REQ-035 SHALL, on error, leave the memory unmodified and respond with d_error=1, d_data=0, and d_opcode=1 for Get or 0 otherwise (0 for an illegal opcode).
REQ-036 SHALL give a last-byte address exactly at the range limit (BASE+MEM_DEPTH*MASK_WIDTH-MASK_WIDTH) a legal response; the next word up is an error, and the address arithmetic SHALL NOT wrap.
REQ-037 SHALL return new data for a Get issued after a Put to the same word has been acknowledged.
REQ-038 SHALL ignore a_valid while not in IDLE, and SHALL NOT assume the requester holds it.

Reset
REQ-039 SHALL, while reset_n=0: state=IDLE, counter=0, a_ready=0, d_valid=0, d_error=0, d_data=0, and mem_busy=0; a_ready rises in the first cycle after reset_n deasserts.
REQ-040 SHALL, on reset mid-operation, drop the pending response with no write performed if the write edge was not reached; memory contents SHALL NOT be reset.

Structure
REQ-041 SHALL take the opcode enums, OPCODE/PARAM/SIZE/SINK_WIDTH (3/3/3/1) and the FSM state typedef from the shared package tl_pkg.
REQ-042 SHALL place storage in a single sub-module tl_mem_array (byte-masked write, registered read).

Verification
REQ-043 SHALL cover: PutFull to 0x10 with data 0xDEADBEEF and mask 0xF, then Get 0x10 with source 2 -> AccessAck, then AccessAckData with data 0xDEADBEEF, d_source=2, d_error=0.
REQ-044 SHALL cover: PutPartial to 0x10 with data 0x000000AA and mask 0x1 -> a later Get returns 0xDEADBEAA.
REQ-045 SHALL cover: Get 0x400 with MEM_DEPTH=256 -> d_error=1, d_data=0; Get 0x3FC -> d_error=0.
REQ-046 SHALL cover: LATENCY=3 with d_ready held low for 5 cycles -> d_valid rises 4 cycles after accept, fields are stable, and a_ready=0 throughout.
REQ-047 SHALL cover: reset_n pulsed low in WAIT during a Put -> d_valid=0 immediately, the word is unchanged, and a_ready=1 in the first cycle after release.
